// File: rtl/spi_reg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_ctrl_if
// Brief   : Byte handshake between the SPI slave PHY (master) and the register
//           controller (slave): RX byte strobe in, TX byte load out.
// Revision: 1.0 - initial release
// ============================================================================
interface spi_reg_ctrl_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;

  modport master (
    output i_RX_DV,
    output i_RX_Byte,
    input  o_TX_DV,
    input  o_TX_Byte
  );

  modport slave (
    input  i_RX_DV,
    input  i_RX_Byte,
    output o_TX_DV,
    output o_TX_Byte
  );
endinterface
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_ctrl
// Brief   : SPI command decoder with register read/write bursts, address
//           auto-increment, TX byte preload and a flattened register file.
// Revision: 1.0 - initial release
// ============================================================================
module spi_reg_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  spi_reg_ctrl_if.slave         bus,
  input  logic                  i_SPI_CS_n,
  input  logic [7:0]            i_Status,
  output logic [NUM_REGS*8-1:0] o_Regs,
  output logic                  o_Wr_Stb,
  output logic [ADDR_W-1:0]     o_Wr_Addr,
  output logic                  o_Busy,
  output logic [7:0]            o_Err_Cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [7:0]        c_NUM_REGS8 = 8'(NUM_REGS);

  state_t              r_state;
  logic                r_cs_meta;
  logic                r_cs_sync;
  logic [ADDR_W-1:0]   r_ptr;
  logic [7:0]          r_regs [NUM_REGS];
  logic                r_tx_dv;
  logic [7:0]          r_tx_byte;
  logic                r_wr_stb;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_busy;
  logic [7:0]          r_err_cnt;

  logic                w_cs_act;
  logic                w_addr_bad;
  logic [ADDR_W-1:0]   w_cmd_ptr;
  logic [ADDR_W-1:0]   w_ptr_inc;

  assign w_cs_act   = ~r_cs_sync;
  assign w_addr_bad = ({1'b0, bus.i_RX_Byte[6:0]} >= c_NUM_REGS8);
  assign w_cmd_ptr  = bus.i_RX_Byte[ADDR_W-1:0];
  assign w_ptr_inc  = (r_ptr == c_LAST_ADDR) ? '0 : r_ptr + ADDR_W'(1);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state   <= S_IDLE;
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
      r_ptr     <= '0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_busy    <= 1'b0;
      r_err_cnt <= 8'h00;
      for (int n = 0; n < NUM_REGS; n++) begin
        r_regs[n] <= 8'h00;
      end
    end else begin
      r_cs_meta <= i_SPI_CS_n;
      r_cs_sync <= r_cs_meta;
      r_wr_stb  <= 1'b0;
      r_tx_dv   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // Keep the slave's preload refreshed with live status until selected.
          r_tx_dv   <= 1'b1;
          r_tx_byte <= i_Status;
          if (w_cs_act) begin
            r_state <= S_CMD;
            r_busy  <= 1'b1;
            r_tx_dv <= 1'b0;
          end
        end
        S_CMD: begin
          if (bus.i_RX_DV) begin
            if (w_addr_bad) begin
              r_state <= S_DRAIN;
              if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
              end
            end else begin
              r_ptr <= w_cmd_ptr;
              if (bus.i_RX_Byte[7]) begin
                r_state <= S_WRITE;
              end else begin
                r_state   <= S_READ;
                r_tx_dv   <= 1'b1;
                r_tx_byte <= r_regs[w_cmd_ptr];
              end
            end
          end
        end
        S_WRITE: begin
          if (bus.i_RX_DV) begin
            r_regs[r_ptr] <= bus.i_RX_Byte;
            r_wr_stb      <= 1'b1;
            r_wr_addr     <= r_ptr;
            r_tx_dv       <= 1'b1;
            r_tx_byte     <= bus.i_RX_Byte;
            r_ptr         <= w_ptr_inc;
          end
        end
        S_READ: begin
          if (bus.i_RX_DV) begin
            r_ptr     <= w_ptr_inc;
            r_tx_dv   <= 1'b1;
            r_tx_byte <= r_regs[w_ptr_inc];
          end
        end
        S_DRAIN: begin
          if (bus.i_RX_DV) begin
            r_tx_dv   <= 1'b1;
            r_tx_byte <= 8'h00;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Deselect wins over the byte-driven transition, but the byte above still lands.
      if ((r_state != S_IDLE) && !w_cs_act) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign o_Regs[8*g +: 8] = r_regs[g];
    end
  endgenerate

  assign bus.o_TX_DV   = r_tx_dv;
  assign bus.o_TX_Byte = r_tx_byte;
  assign o_Wr_Stb      = r_wr_stb;
  assign o_Wr_Addr     = r_wr_addr;
  assign o_Busy        = r_busy;
  assign o_Err_Cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_reg_ctrl
// Brief   : Self-checking bench for spi_reg_ctrl against a transaction model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic [7:0]  status;
  logic [63:0] regs;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic        busy;
  logic [7:0]  err_cnt;

  spi_reg_ctrl_if bus ();

  spi_reg_ctrl #(.NUM_REGS(8), .ADDR_W(3)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .bus        (bus),
    .i_SPI_CS_n (cs_n),
    .i_Status   (status),
    .o_Regs     (regs),
    .o_Wr_Stb   (wr_stb),
    .o_Wr_Addr  (wr_addr),
    .o_Busy     (busy),
    .o_Err_Cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_regs [8];
  int         m_err;

  logic [7:0] tq [$];
  logic [7:0] exp_tx [$];
  int         exp_wr [$];
  logic [7:0] cap_tx [$];
  int         cap_wr [$];

  // Collect transaction-time TX loads and register writes
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_TX_DV && busy) cap_tx.push_back(bus.o_TX_Byte);
      if (wr_stb) cap_wr.push_back(int'(wr_addr) * 256 + int'(regs[8*wr_addr +: 8]));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one CS-framed transaction from tq and compare with the model
  task automatic run_txn(input string tag);
    int a;
    int n;
    logic [7:0] cmd;
    exp_tx.delete();
    exp_wr.delete();
    cmd = tq[0];
    a   = int'(cmd[6:0]);
    n   = tq.size() - 1;
    if (a >= 8) begin
      if (m_err < 255) m_err++;
      for (int i = 1; i <= n; i++) exp_tx.push_back(8'h00);
    end else if (cmd[7]) begin
      for (int i = 1; i <= n; i++) begin
        int idx;
        idx = (a + i - 1) % 8;
        m_regs[idx] = tq[i];
        exp_wr.push_back(idx * 256 + int'(tq[i]));
        exp_tx.push_back(tq[i]);
      end
    end else begin
      exp_tx.push_back(m_regs[a]);
      for (int i = 1; i <= n; i++) exp_tx.push_back(m_regs[(a + i) % 8]);
    end

    cap_tx.delete();
    cap_wr.delete();
    cs_n = 1'b0;
    repeat (4) tick();
    for (int i = 0; i <= n; i++) begin
      bus.i_RX_Byte = tq[i];
      bus.i_RX_DV   = 1'b1;
      tick();
      bus.i_RX_DV   = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    cs_n = 1'b1;
    repeat (4) tick();

    chk({tag, " tx_count"}, 64'(cap_tx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < cap_tx.size() && i < exp_tx.size(); i++)
      chk({tag, " tx_byte"}, 64'(cap_tx[i]), 64'(exp_tx[i]));
    chk({tag, " wr_count"}, 64'(cap_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < cap_wr.size() && i < exp_wr.size(); i++)
      chk({tag, " wr_addr_data"}, 64'(cap_wr[i]), 64'(exp_wr[i]));
    chk({tag, " regs"}, regs, model_flat());
    chk({tag, " err_cnt"}, 64'(err_cnt), 64'(m_err));
  endtask

  initial begin
    rst           = 1'b1;
    cs_n          = 1'b1;
    status        = 8'h00;
    bus.i_RX_DV   = 1'b0;
    bus.i_RX_Byte = 8'h00;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_err = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tx_dv", 64'(bus.o_TX_DV), 64'd0);
    chk("rst tx_byte", 64'(bus.o_TX_Byte), 64'd0);
    chk("rst wr_stb", 64'(wr_stb), 64'd0);
    chk("rst wr_addr", 64'(wr_addr), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst err", 64'(err_cnt), 64'd0);
    chk("rst regs", regs, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();

    // Write burst
    tq = '{8'h82, 8'hAA, 8'hBB};
    run_txn("wr_burst");
    chk("wr_burst reg2", 64'(regs[23:16]), 64'hAA);
    chk("wr_burst reg3", 64'(regs[31:24]), 64'hBB);

    // Read with wrap: preload 6,7,0 then read 4 bytes from 6
    tq = '{8'h86, 8'h11, 8'h22, 8'h33};
    run_txn("preload");
    tq = '{8'h06, 8'h00, 8'h00, 8'h00};
    run_txn("rd_wrap");
    if (cap_tx.size() == 4) begin
      chk("rd_wrap byte0", 64'(cap_tx[0]), 64'h11);
      chk("rd_wrap byte3", 64'(cap_tx[3]), 64'h00);
    end

    // Status preload in idle, then busy after select
    status = 8'h5A;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle tx_dv", 64'(bus.o_TX_DV), 64'd1);
      chk("idle tx_byte", 64'(bus.o_TX_Byte), 64'h5A);
    end
    tick();
    cs_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("select busy", 64'(busy), 64'd1);
    chk("select tx_dv", 64'(bus.o_TX_DV), 64'd0);
    tick();
    cs_n = 1'b1;
    repeat (4) tick();

    // Bad address, then saturation
    tq = '{8'h89, 8'h12, 8'h34};
    run_txn("bad_addr");
    chk("bad_addr err1", 64'(err_cnt), 64'd1);
    for (int k = 0; k < 299; k++) begin
      tq = '{8'h89, 8'h55};
      run_txn("bad_sat");
    end
    chk("err saturated", 64'(err_cnt), 64'hFF);

    // Abort after a write command with a partial data byte
    cs_n = 1'b0;
    repeat (4) tick();
    bus.i_RX_Byte = 8'h81;
    bus.i_RX_DV   = 1'b1;
    tick();
    bus.i_RX_DV   = 1'b0;
    repeat (2) tick();
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort idle", 64'(busy), 64'd0);
    chk("abort reg1", 64'(regs[15:8]), 64'(m_regs[1]));
    tick();
    repeat (2) tick();

    // Byte arriving in the same cycle the synchronized select drops
    cs_n = 1'b0;
    repeat (4) tick();
    bus.i_RX_Byte = 8'h81;
    bus.i_RX_DV   = 1'b1;
    tick();
    bus.i_RX_DV   = 1'b0;
    repeat (2) tick();
    cs_n = 1'b1;
    tick();
    tick();
    bus.i_RX_Byte = 8'h5C;
    bus.i_RX_DV   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_RX_DV   = 1'b0;
    m_regs[1] = 8'h5C;
    chk("coinc wr_stb", 64'(wr_stb), 64'd1);
    chk("coinc wr_addr", 64'(wr_addr), 64'd1);
    chk("coinc busy", 64'(busy), 64'd0);
    chk("coinc regs", regs, model_flat());
    tick();
    repeat (3) tick();

    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      int len;
      status = 8'($urandom);
      tq.delete();
      tq.push_back({1'($urandom_range(0, 1)), 7'($urandom_range(0, 11))});
      len = $urandom_range(0, 5);
      for (int i = 0; i < len; i++) tq.push_back(8'($urandom));
      run_txn("random");
    end

    // Reset in the middle of a write burst
    cs_n = 1'b0;
    repeat (4) tick();
    bus.i_RX_Byte = 8'h80;
    bus.i_RX_DV   = 1'b1;
    tick();
    bus.i_RX_Byte = 8'h77;
    tick();
    bus.i_RX_DV   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst tx_dv", 64'(bus.o_TX_DV), 64'd0);
    chk("midrst tx_byte", 64'(bus.o_TX_Byte), 64'd0);
    chk("midrst wr_stb", 64'(wr_stb), 64'd0);
    chk("midrst wr_addr", 64'(wr_addr), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst err", 64'(err_cnt), 64'd0);
    chk("midrst regs", regs, 64'd0);
    tick();
    cs_n = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_err = 0;
    repeat (3) tick();
    tq = '{8'h87, 8'hC3, 8'h3C};
    run_txn("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register controller behind the SPI slave. It decodes the received byte stream into register read and write bursts with address auto-increment.
- It drives the slave's TX byte-load handshake so read data, status and echo bytes are ready before each byte is shifted out.
- It holds the block's configuration register file and exposes it flattened to the DDA core.

Parameters:
- NUM_REGS, 8, number of 8-bit configuration registers; legal range 2..128.
- ADDR_W, 3, register address width; must equal clog2(NUM_REGS).

Ports:
- i_Clk  input  1  system clock, same clock that drives the SPI slave's system-side logic.
- i_Rst  input  1  synchronous, active-high reset.
- i_RX_DV  input  1  one-cycle pulse from the slave: i_RX_Byte is valid.
- i_RX_Byte  input  8  received byte.
- i_SPI_CS_n  input  1  raw SPI chip select, asynchronous; synchronized internally.
- i_Status  input  8  status byte, returned during each command byte.
- o_TX_DV  output  1  load strobe for the slave's TX byte.
- o_TX_Byte  output  8  byte the slave shifts out next.
- o_Regs  output  NUM_REGS*8  flattened register file; reg n occupies bits [8n+7:8n].
- o_Wr_Stb  output  1  one-cycle pulse when a register is written.
- o_Wr_Addr  output  ADDR_W  address of the write flagged by o_Wr_Stb.
- o_Busy  output  1  high while a transaction is active (state other than IDLE).
- o_Err_Cnt  output  8  saturating count of commands that used an out-of-range address.

Behaviour:
- Reset (synchronous, i_Rst=1 at a clock edge):
  - o_Regs=0, o_TX_DV=0, o_TX_Byte=0x00, o_Wr_Stb=0, o_Wr_Addr=0, o_Busy=0, o_Err_Cnt=0.
  - State=IDLE, address pointer=0, CS synchronizer flops=1.
  - Reset overrides everything, including mid-transaction.
- CS_n passes through a 2-flop synchronizer; cs_act = ~synchronized value.
- Command byte format: bit7=1 means write, 0 means read; bits[6:0] are the address.
- States: IDLE, CMD, WRITE, READ, DRAIN.
- IDLE:
  - o_TX_DV=1 every cycle with o_TX_Byte=i_Status, so the slave's preload always holds current status.
  - cs_act=1 moves to CMD. o_TX_DV is 0 from that cycle.
- CMD, on i_RX_DV:
  - Address bits[6:0] >= NUM_REGS: go to DRAIN; o_Err_Cnt increments, saturating at 0xFF.
  - Write command: pointer=addr; go to WRITE.
  - Read command: pointer=addr; go to READ; next cycle o_TX_DV=1 with o_TX_Byte=reg[addr].
- WRITE, on i_RX_DV at cycle t:
  - At t+1: reg[pointer]=byte, o_Wr_Stb=1, o_Wr_Addr=pointer.
  - Also at t+1: o_TX_DV=1 with o_TX_Byte=received byte (echo).
  - Pointer increments.
- READ, on i_RX_DV at cycle t (received byte ignored):
  - Pointer increments.
  - At t+1: o_TX_DV=1 with o_TX_Byte=reg[new pointer].
- Pointer increment wraps from NUM_REGS-1 to 0.
- DRAIN:
  - Received bytes are ignored; no register changes.
  - On each i_RX_DV, next cycle o_TX_DV=1 with o_TX_Byte=0x00.
- From any non-IDLE state, cs_act=0 returns to IDLE on the next edge. A CS_n rise therefore reaches IDLE within 3 clocks; a partial byte is discarded.
- i_RX_DV in the same cycle cs_act falls: the byte is processed normally (a write still commits), then the state goes to IDLE.
- i_RX_DV while in IDLE is ignored.
- o_Wr_Stb and non-IDLE o_TX_DV are exactly one cycle wide.
- Registers hold their value across transactions.
- o_Busy = (state != IDLE), registered.

Test Plan:
1. Write burst: reset; CS low; bytes 0x82,0xAA,0xBB → reg2=0xAA, reg3=0xBB. o_Wr_Stb pulses with o_Wr_Addr=2 then 3. Echo TX bytes are 0xAA, 0xBB.
2. Read with wrap: preload reg6=0x11, reg7=0x22, reg0=0x33; command 0x06 plus 3 dummy bytes → o_TX_Byte sequence 0x11, 0x22, 0x33, 0x00 (reg1); no o_Wr_Stb.
3. Status/idle: i_Status=0x5A, CS high → o_TX_DV=1 and o_TX_Byte=0x5A continuously. CS low → o_TX_DV drops; o_Busy=1 within 3 cycles.
4. Bad address: command 0x89 (NUM_REGS=8) plus 2 data bytes → o_Regs unchanged, o_Err_Cnt=1, TX bytes 0x00. Repeat 300 times → o_Err_Cnt stays at 0xFF.
5. Abort: raise CS after command 0x81 and 3 bits of data → IDLE within 3 cycles, reg1 unchanged. i_RX_DV coincident with the CS rise → write commits.
6. Reset mid-write: assert i_Rst during WRITE → all outputs reset values next edge, state IDLE, o_Regs=0.
